// File: rtl/pipe_stall_stage.sv
// IF/ID and ID/EX pipeline registers with load-use stall,
// branch flush, and a saturating stall-cycle counter.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic [4:0]  td;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
  } id_ex_t;

endpackage

module pipe_stall_stage
  import pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] if_pc,
  input  logic [31:0]  if_inst,
  input  logic         id_wreg,
  input  logic         id_m2reg,
  input  logic         id_wmem,
  input  logic [4:0]   id_dest,
  input  logic [3:0]   id_aluc,
  input  logic [W-1:0] id_a,
  input  logic [W-1:0] id_b,
  output logic         pc_en,
  output logic [W-1:0] ifid_pc,
  output logic [31:0]  ifid_inst,
  output logic         ifid_valid,
  output logic         ex_wreg,
  output logic         ex_m2reg,
  output logic         ex_wmem,
  output logic [3:0]   ex_aluc,
  output logic [W-1:0] ex_a,
  output logic [W-1:0] ex_b,
  output logic [4:0]   ex_td,
  output logic         ex_lw,
  output logic [7:0]   stall_cnt
);

  logic [W-1:0] ifid_pc_q;
  logic [W-1:0] ifid_pc_d;
  logic [W-1:0] ex_a_q;
  logic [W-1:0] ex_a_d;
  logic [W-1:0] ex_b_q;
  logic [W-1:0] ex_b_d;

  if_id_t ifid_q;
  if_id_t ifid_d;
  id_ex_t idex_q;
  id_ex_t idex_d;

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  logic ifid_ld;
  logic ifid_sq;

  assign pc_en   = ~stall;
  assign ifid_ld = ~stall & ~flush;
  assign ifid_sq = ~stall & flush;

  // Stall outranks flush; ID re-raises the flush once released.
  always_comb begin
    ifid_d    = ifid_q;
    ifid_pc_d = ifid_pc_q;
    unique case (1'b1)
      stall: begin
        ifid_d    = ifid_q;
        ifid_pc_d = ifid_pc_q;
      end
      ifid_sq: begin
        ifid_d.inst  = 32'h0;
        ifid_d.valid = 1'b0;
        ifid_pc_d    = if_pc;
      end
      ifid_ld: begin
        ifid_d.inst  = if_inst;
        ifid_d.valid = 1'b1;
        ifid_pc_d    = if_pc;
      end
      default: begin
        ifid_d    = ifid_q;
        ifid_pc_d = ifid_pc_q;
      end
    endcase
    ifid_d.pc = 32'(ifid_pc_d);
  end

  always_comb begin
    idex_d = '0;
    ex_a_d = '0;
    ex_b_d = '0;
    if (!stall) begin
      idex_d.wreg  = id_wreg & ifid_q.valid;
      idex_d.m2reg = id_m2reg & ifid_q.valid;
      idex_d.wmem  = id_wmem & ifid_q.valid;
      idex_d.aluc  = id_aluc;
      idex_d.td    = id_dest;
      idex_d.valid = ifid_q.valid;
      ex_a_d       = id_a;
      ex_b_d       = id_b;
    end
    idex_d.a = 32'(ex_a_d);
    idex_d.b = 32'(ex_b_d);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q    <= '0;
      ifid_pc_q <= '0;
      idex_q    <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      cnt_q     <= '0;
    end else begin
      ifid_q    <= ifid_d;
      ifid_pc_q <= ifid_pc_d;
      idex_q    <= idex_d;
      ex_a_q    <= ex_a_d;
      ex_b_q    <= ex_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ifid_pc    = ifid_pc_q;
  assign ifid_inst  = ifid_q.inst;
  assign ifid_valid = ifid_q.valid;
  assign ex_wreg    = idex_q.wreg;
  assign ex_m2reg   = idex_q.m2reg;
  assign ex_wmem    = idex_q.wmem;
  assign ex_aluc    = idex_q.aluc;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_td      = idex_q.td;
  assign stall_cnt  = cnt_q;

  // A load targeting $0 never creates a hazard.
  assign ex_lw = idex_q.m2reg & idex_q.valid & (|idex_q.td);

  logic unused_ok;
  assign unused_ok = ^{idex_q.a, idex_q.b, ifid_q.pc};

endmodule

// File: tb/tb_pipe_stall_stage.sv
// Randomized and directed bench for pipe_stall_stage
// against a cycle-level reference model.
module tb_pipe_stall_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] if_pc = '0;
  logic [31:0]  if_inst = '0;
  logic         id_wreg = 1'b0;
  logic         id_m2reg = 1'b0;
  logic         id_wmem = 1'b0;
  logic [4:0]   id_dest = '0;
  logic [3:0]   id_aluc = '0;
  logic [W-1:0] id_a = '0;
  logic [W-1:0] id_b = '0;
  logic         pc_en;
  logic [W-1:0] ifid_pc;
  logic [31:0]  ifid_inst;
  logic         ifid_valid;
  logic         ex_wreg;
  logic         ex_m2reg;
  logic         ex_wmem;
  logic [3:0]   ex_aluc;
  logic [W-1:0] ex_a;
  logic [W-1:0] ex_b;
  logic [4:0]   ex_td;
  logic         ex_lw;
  logic [7:0]   stall_cnt;

  pipe_stall_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_inst(if_inst),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_dest(id_dest),
    .id_aluc(id_aluc), .id_a(id_a), .id_b(id_b),
    .pc_en(pc_en), .ifid_pc(ifid_pc),
    .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .ex_wmem(ex_wmem), .ex_aluc(ex_aluc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_td(ex_td),
    .ex_lw(ex_lw), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Reference state
  logic [W-1:0] m_pc;
  logic [31:0]  m_inst;
  logic         m_v;
  logic         m_wreg, m_m2reg, m_wmem, m_ev;
  logic [3:0]   m_aluc;
  logic [4:0]   m_td;
  logic [W-1:0] m_a, m_b;
  int           m_cnt;

  task automatic m_reset();
    m_pc = '0; m_inst = '0; m_v = 0;
    m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_ev = 0;
    m_aluc = '0; m_td = '0; m_a = '0; m_b = '0;
    m_cnt = 0;
  endtask

  task automatic m_edge();
    if (stall) begin
      m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_ev = 0;
      m_aluc = '0; m_td = '0; m_a = '0; m_b = '0;
    end else begin
      m_wreg  = m_v && id_wreg;
      m_m2reg = m_v && id_m2reg;
      m_wmem  = m_v && id_wmem;
      m_ev    = m_v;
      m_aluc  = id_aluc; m_td = id_dest;
      m_a = id_a; m_b = id_b;
      m_pc = if_pc;
      m_inst = flush ? 32'h0 : if_inst;
      m_v = !flush;
    end
    if (stall) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
  endtask

  task automatic chk_all(input string p);
    chk({p, "_ifid_pc"}, 64'(ifid_pc), 64'(m_pc));
    chk({p, "_ifid_inst"}, 64'(ifid_inst), 64'(m_inst));
    chk({p, "_ifid_valid"}, 64'(ifid_valid), 64'(m_v));
    chk({p, "_ex_wreg"}, 64'(ex_wreg), 64'(m_wreg));
    chk({p, "_ex_m2reg"}, 64'(ex_m2reg), 64'(m_m2reg));
    chk({p, "_ex_wmem"}, 64'(ex_wmem), 64'(m_wmem));
    chk({p, "_ex_aluc"}, 64'(ex_aluc), 64'(m_aluc));
    chk({p, "_ex_td"}, 64'(ex_td), 64'(m_td));
    chk({p, "_ex_a"}, 64'(ex_a), 64'(m_a));
    chk({p, "_ex_b"}, 64'(ex_b), 64'(m_b));
    chk({p, "_ex_lw"}, 64'(ex_lw),
        64'(m_m2reg && m_ev && m_td != 0));
    chk({p, "_stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  // Called just after a negedge with inputs already set.
  task automatic step(input string p);
    #1;
    chk({p, "_pc_en"}, 64'(pc_en), 64'(!stall));
    @(posedge clk);
    m_edge();
    #1;
    chk_all(p);
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic f,
                        input logic [31:0] inst,
                        input logic w, input logic m,
                        input logic [4:0] d);
    stall = s; flush = f;
    if_pc = if_pc + 4; if_inst = inst;
    id_wreg = w; id_m2reg = m; id_wmem = 0;
    id_dest = d; id_aluc = 4'(d);
    id_a = $urandom; id_b = $urandom;
  endtask

  task automatic rnd_in();
    stall = ($urandom_range(0, 9) < 3);
    flush = ($urandom_range(0, 9) < 2);
    if_pc = $urandom; if_inst = $urandom;
    id_wreg = 1'($urandom); id_m2reg = 1'($urandom);
    id_wmem = 1'($urandom);
    id_dest = ($urandom_range(0, 3) == 0) ? 5'd0
              : 5'($urandom);
    id_aluc = 4'($urandom);
    id_a = $urandom; id_b = $urandom;
  endtask

  logic [31:0] held;

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    #1 chk_all("rst");
    chk("rst_pc_en", 64'(pc_en), 64'(1));
    rst_n = 1'b1;

    // Load-use: lw x5 enters EX, then one stall cycle
    set_in(0, 0, 32'h0000_2283, 0, 0, 0); step("fill");
    set_in(0, 0, 32'h0053_0333, 1, 1, 5); step("lw");
    chk("lu_ex_lw", 64'(ex_lw), 64'(1));
    chk("lu_ex_td", 64'(ex_td), 64'(5));
    held = ifid_inst;
    set_in(1, 0, 32'h1111_1111, 1, 0, 6);
    #1 chk("lu_pc_en", 64'(pc_en), 64'(0));
    step("stl");
    chk("lu_bub_lw", 64'(ex_lw), 64'(0));
    chk("lu_bub_wreg", 64'(ex_wreg), 64'(0));
    chk("lu_hold", 64'(ifid_inst), 64'(held));
    set_in(0, 0, 32'h0000_0013, 1, 0, 6); step("dep");
    chk("lu_dep_wreg", 64'(ex_wreg), 64'(1));
    chk("lu_dep_td", 64'(ex_td), 64'(6));

    // Flush
    set_in(0, 1, 32'h2108_0001, 1, 0, 7); step("fl");
    chk("fl_inst", 64'(ifid_inst), 64'(0));
    chk("fl_valid", 64'(ifid_valid), 64'(0));
    set_in(0, 0, 32'h0000_0013, 1, 1, 8); step("fl2");
    chk("fl_ex_wreg", 64'(ex_wreg), 64'(0));
    chk("fl_ex_lw", 64'(ex_lw), 64'(0));

    // Stall with flush: no squash
    set_in(0, 0, 32'hCAFE_0001, 0, 0, 1); step("sf0");
    held = ifid_inst;
    set_in(1, 1, 32'hDEAD_0002, 1, 1, 3); step("sf");
    chk("sf_hold", 64'(ifid_inst), 64'(held));
    chk("sf_valid", 64'(ifid_valid), 64'(1));
    chk("sf_bub", 64'(ex_wreg), 64'(0));

    // Load to $0
    set_in(0, 0, 32'h0000_0003, 1, 1, 0); step("z");
    chk("z_m2reg", 64'(ex_m2reg), 64'(1));
    chk("z_lw", 64'(ex_lw), 64'(0));

    // Async reset mid-stall
    set_in(1, 0, 32'h0, 0, 0, 0); step("rs0");
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 32'h0ABC_0001, 0, 0, 0); step("rs1");
    chk("rs_load", 64'(ifid_inst), 64'(32'h0ABC_0001));

    // Saturation
    for (int i = 0; i < 300; i++) begin
      rnd_in(); stall = 1'b1; step("sat");
    end
    chk("sat_cnt", 64'(stall_cnt), 64'(255));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rnd_in(); step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
